// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the fetch stage.
//
// After reset the PC is held at RESET_VEC for HOLD_CYCLES+1 edges, then
// presented under a valid/ready handshake. Trap and branch redirects take
// priority over sequential increment. A halt request parks the generator in
// HALT until resume or a trap. Redirects that arrive while the PC cannot
// follow them (HOLD, HALT) are kept in a single pending-target latch.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   if_ready     fetch stage accepts current pc
//   if_valid     pc is a valid fetch request (state == RUN)
//   pc           current fetch address
//   trap_valid   trap/exception redirect request
//   trap_target  trap target address
//   br_valid     branch/jump redirect request
//   br_target    branch target address
//   halt_req     request to stop fetching
//   resume       leave HALT
//   halted       state == HALT
//   fetch_cnt    count of accepted fetches (valid & ready), wraps
//
// state  | meaning
// -------+------------------------------------------------------------
// S_HOLD | post-reset hold; pc = RESET_VEC, redirects go to pending
// S_RUN  | fetching; if_valid = 1
// S_HALT | stopped; branches go to pending, trap or resume restarts

module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter int              INC         = 4,
  parameter int              ALIGN_BITS  = 2,
  parameter int              HOLD_CYCLES = 1,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int HC_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] trap_al, br_al, pc_inc;
  logic            fire;

  assign trap_al = trap_target & ALIGN_MASK;
  assign br_al   = br_target & ALIGN_MASK;
  assign pc_inc  = pc + XLEN'(INC);
  // if_valid is a registered copy of (state == S_RUN)
  assign fire    = if_valid & if_ready;

  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    pc_nxt          = pc;

    case (state)
      S_HOLD: begin
        if (trap_valid) begin
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = trap_al;
        end else if (br_valid) begin
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = br_al;
        end
        if (hold_cnt == '0) begin
          // a request arriving on the exit edge is the newest one, so it wins
          state_nxt      = S_RUN;
          pend_valid_nxt = 1'b0;
          if (trap_valid)      pc_nxt = trap_al;
          else if (br_valid)   pc_nxt = br_al;
          else if (pend_valid) pc_nxt = pend_target;
        end else begin
          hold_cnt_nxt = hold_cnt - HC_W'(1);
        end
      end

      S_RUN: begin
        if (trap_valid)    pc_nxt = trap_al;
        else if (br_valid) pc_nxt = br_al;
        else if (fire)     pc_nxt = pc_inc;
        if (halt_req) state_nxt = S_HALT;
      end

      S_HALT: begin
        if (trap_valid) begin
          pc_nxt         = trap_al;
          state_nxt      = S_RUN;
          pend_valid_nxt = 1'b0;
        end else if (resume) begin
          state_nxt      = S_RUN;
          pend_valid_nxt = 1'b0;
          if (br_valid)        pc_nxt = br_al;
          else if (pend_valid) pc_nxt = pend_target;
        end else if (br_valid) begin
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = br_al;
        end
      end

      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HOLD;
      hold_cnt    <= HC_W'(HOLD_CYCLES);
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pc          <= RESET_VEC;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      pc          <= pc_nxt;
      if_valid    <= (state_nxt == S_RUN);
      halted      <= (state_nxt == S_HALT);
      if (fire) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int HOLD_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] pc;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        br_valid;
  logic [31:0] br_target;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0000_0000), .INC(4), .ALIGN_BITS(2),
    .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .if_valid(if_valid), .pc(pc),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .br_valid(br_valid), .br_target(br_target),
    .halt_req(halt_req), .resume(resume), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // started: hold phase over; m_halted: parked; m_pend: every deferred
  // redirect in arrival order, the newest one is the one that counts.
  bit          m_started;
  bit          m_halted;
  int          m_edges;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_pend[$];

  function automatic logic [31:0] al(input logic [31:0] x);
    return {x[31:2], 2'b00};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_halted = 0; m_edges = 0;
      m_pc = 32'h0; m_cnt = 32'h0; m_pend.delete();
    end else if (!m_started) begin
      if (trap_valid)    m_pend.push_back(al(trap_target));
      else if (br_valid) m_pend.push_back(al(br_target));
      if (m_edges == HOLD_CYCLES) begin
        m_started = 1;
        if (m_pend.size() > 0) m_pc = m_pend[$];
        m_pend.delete();
      end
      m_edges++;
    end else if (!m_halted) begin
      if (if_ready) m_cnt = m_cnt + 1;
      if (trap_valid)    m_pc = al(trap_target);
      else if (br_valid) m_pc = al(br_target);
      else if (if_ready) m_pc = m_pc + 4;
      if (halt_req) m_halted = 1;
    end else begin
      if (trap_valid) begin
        m_pc = al(trap_target); m_halted = 0; m_pend.delete();
      end else if (resume) begin
        if (br_valid) m_pend.push_back(al(br_target));
        if (m_pend.size() > 0) m_pc = m_pend[$];
        m_pend.delete();
        m_halted = 0;
      end else if (br_valid) begin
        m_pend.push_back(al(br_target));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_pc", pc, m_pc);
    check("model_fetch_cnt", fetch_cnt, m_cnt);
    check("model_if_valid", {31'b0, if_valid}, {31'b0, m_started && !m_halted});
    check("model_halted", {31'b0, halted}, {31'b0, m_halted});
  end

  // apply inputs for one rising edge, return at the following falling edge
  task automatic step(input logic tv, input logic [31:0] tt, input logic bv,
                      input logic [31:0] bt, input logic rdy, input logic hr,
                      input logic rs);
    trap_valid = tv; trap_target = tt; br_valid = bv; br_target = bt;
    if_ready = rdy; halt_req = hr; resume = rs;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(0, 32'h0, 0, 32'h0, rdy, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; if_ready = 1; trap_valid = 0; trap_target = 0;
    br_valid = 0; br_target = 0; halt_req = 0; resume = 0;
    @(negedge clk); @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_cnt", fetch_cnt, 32'h0);

    rst = 0;
    idle(1);
    check("hold_edge1_valid", {31'b0, if_valid}, 32'h0);
    idle(1);
    check("hold_edge2_valid", {31'b0, if_valid}, 32'h1);
    check("first_pc", pc, 32'h0);
    idle(1); check("seq_pc1", pc, 32'h4);
    idle(1); check("seq_pc2", pc, 32'h8);
    idle(1); check("cnt_after3", fetch_cnt, 32'd3);
    idle(1); check("pc_0x10", pc, 32'h10);

    // backpressure
    idle(0); idle(0); idle(0);
    check("bp_pc", pc, 32'h10);
    check("bp_cnt", fetch_cnt, 32'd4);
    idle(1);
    check("bp_release_pc", pc, 32'h14);

    // simultaneous redirect, alignment
    step(1, 32'h100, 1, 32'h200, 0, 0, 0);
    check("trap_over_br", pc, 32'h100);
    check("redirect_cnt", fetch_cnt, 32'd5);
    step(0, 32'h0, 1, 32'h203, 0, 0, 0);
    check("br_align", pc, 32'h200);
    step(0, 32'h0, 1, 32'h40, 0, 0, 0);
    check("br_0x40", pc, 32'h40);

    // halt with a fire, pending branch, resume
    step(0, 32'h0, 0, 32'h0, 1, 1, 0);
    check("halt_pc", pc, 32'h44);
    check("halt_halted", {31'b0, halted}, 32'h1);
    check("halt_valid", {31'b0, if_valid}, 32'h0);
    step(0, 32'h0, 1, 32'h80, 0, 0, 0);
    check("halt_pc_hold", pc, 32'h44);
    idle(0);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    check("resume_pend_pc", pc, 32'h80);
    check("resume_valid", {31'b0, if_valid}, 32'h1);
    check("resume_halted", {31'b0, halted}, 32'h0);

    // trap wakes HALT and clears pending
    step(0, 32'h0, 0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 1, 32'h90, 0, 0, 0);
    step(1, 32'hC3, 0, 32'h0, 0, 0, 0);
    check("trap_wake_pc", pc, 32'hC0);
    check("trap_wake_valid", {31'b0, if_valid}, 32'h1);
    step(0, 32'h0, 0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    check("resume_nopend_pc", pc, 32'hC0);

    // same-cycle branch beats older pending on resume
    step(0, 32'h0, 0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 1, 32'h300, 0, 0, 0);
    step(0, 32'h0, 1, 32'h404, 0, 0, 1);
    check("resume_br_pc", pc, 32'h404);

    // wrap
    step(0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    check("pre_wrap_pc", pc, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_pc", pc, 32'h0);
    check("wrap_cnt", fetch_cnt, 32'd7);
    idle(1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_valid", {31'b0, if_valid}, 32'h0);
    check("async_cnt", fetch_cnt, 32'h0);
    @(negedge clk);
    rst = 0;
    // redirect and halt request during HOLD
    step(0, 32'h0, 1, 32'h52, 1, 1, 0);
    check("hold_redirect_pc", pc, 32'h0);
    check("hold_redirect_valid", {31'b0, if_valid}, 32'h0);
    idle(0);
    check("hold_exit_pc", pc, 32'h50);
    check("hold_exit_halted", {31'b0, halted}, 32'h0);
    idle(1);
    check("post_hold_pc", pc, 32'h54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
